// File: rtl/ysyx_22040000_ifu_fetch.sv
// Instruction fetch stage: holds the PC and fetches one word at a time for decode.
// Latency: request accept to inst_valid = response latency + 1 cycle; best case one instruction per 3 cycles.
// Backpressure: holds {inst, inst_pc, inst_fault} stable while inst_ready is low, with no new fetch meanwhile.
//
// Ports:
//   clk, rst_n                         clock and asynchronous active-low reset
//   imem_req_valid/ready/addr          fetch request channel (addr = pc while requesting)
//   imem_rsp_valid/data/err            in-order response pulse, data word and access fault
//   inst_valid/ready, inst,
//   inst_pc, inst_fault                instruction channel to decode
//   redirect_valid, redirect_pc        next-PC override from execute
module ysyx_22040000_ifu_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              fault_q;

  logic pc_misaligned;
  logic req_fire;

  // A misaligned PC never reaches memory; it is turned into a faulting
  // instruction directly from REQ instead.
  assign pc_misaligned  = |pc[1:0];
  assign imem_req_valid = (state == S_REQ) && !pc_misaligned;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Address is driven only while requesting so every output reads 0 in reset.
  assign imem_req_addr  = (state == S_REQ) ? pc : '0;

  assign inst_valid = (state == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (redirect_valid) pc <= redirect_pc;
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // A fetch accepted in the redirect cycle is already stale: its
            // response must be swallowed before refetching from the target.
            if (req_fire) begin
              state <= S_WAIT;
              kill  <= 1'b1;
            end
          end else if (pc_misaligned) begin
            state     <= S_HOLD;
            inst_q    <= '0;
            inst_pc_q <= pc;
            fault_q   <= 1'b1;
          end else if (req_fire) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // A response landing in the redirect cycle is dropped right away;
            // otherwise remember to drop the one still in flight.
            if (imem_rsp_valid) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              state     <= S_HOLD;
              inst_q    <= imem_rsp_err ? '0 : imem_rsp_data;
              inst_pc_q <= pc;
              fault_q   <= imem_rsp_err;
            end
          end
        end
        S_HOLD: begin
          // Redirect wins over pc+4 even when decode takes the instruction
          // in the same cycle.
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + ADDR_W'(4);
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040000_ifu_fetch.sv
// Directed testbench for the fetch stage with a simple in-order memory responder.
// Latency: responder answers rsp_lat cycles after request accept (1 = next cycle).
// Backpressure: imem_req_ready and inst_ready driven directly by each scenario.
module tb_ysyx_22040000_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // responder state
  int          rsp_lat  = 1;
  int          rsp_cnt  = 0;
  int          req_count = 0;
  bit          mem_err  = 1'b0;
  logic [31:0] pend_addr = '0;

  ysyx_22040000_ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: sample the handshake at the rising edge, drive the response at
  // the following falling edge. Data word is ~addr, or 0xDEADBEEF with err.
  initial begin
    bit          hs;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (hs) begin
        rsp_cnt   = rsp_lat;
        pend_addr = a;
        req_count++;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_err   = mem_err;
          imem_rsp_data  = mem_err ? 32'hDEAD_BEEF : ~pend_addr;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rsp_lat        = 1;
    mem_err        = 1'b0;
    repeat (2) @(negedge clk);
    rsp_cnt   = 0;
    req_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_inst(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1;
    n_checks++;
    if ({imem_req_valid, inst_valid, inst_fault} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_valids: got %b want 000", {imem_req_valid, inst_valid, inst_fault});
    end
    n_checks++;
    if (inst_pc !== 32'h0 || inst !== 32'h0 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: inst_pc=%h inst=%h addr=%h want all 0", inst_pc, inst, imem_req_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h want 1 80000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc   [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    logic [31:0] exp_inst [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFB, 32'h7FFF_FFF7};
    bit ok;
    do_reset();
    inst_ready = 1'b1;
    wait_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL seq_start: got no request want request within 20 cycles");
    end
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (inst_valid !== (k % 3 == 2) || imem_req_valid !== (k % 3 == 0)) begin
        n_fail++;
        $display("FAIL seq_cycle%0d: inst_valid=%b req_valid=%b want %b %b",
                 k, inst_valid, imem_req_valid, (k % 3 == 2), (k % 3 == 0));
      end
      if (k % 3 == 0) begin
        n_checks++;
        if (imem_req_addr !== exp_pc[k/3]) begin
          n_fail++;
          $display("FAIL seq_addr%0d: got %h want %h", k / 3, imem_req_addr, exp_pc[k/3]);
        end
      end
      if (k % 3 == 2) begin
        n_checks++;
        if (inst_pc !== exp_pc[k/3] || inst !== exp_inst[k/3] || inst_fault !== 1'b0) begin
          n_fail++;
          $display("FAIL seq_inst%0d: pc=%h inst=%h fault=%b want %h %h 0",
                   k / 3, inst_pc, inst, inst_fault, exp_pc[k/3], exp_inst[k/3]);
        end
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    wait_inst(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_first: got no inst_valid want inst_valid within 20 cycles");
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || inst !== 32'h7FFF_FFFF ||
          inst_pc !== 32'h8000_0000) begin
        n_fail++;
        $display("FAIL stall_hold%0d: iv=%b rv=%b inst=%h pc=%h want 1 0 7fffffff 80000000",
                 k, inst_valid, imem_req_valid, inst, inst_pc);
      end
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: rv=%b addr=%h iv=%b want 1 80000004 0",
               imem_req_valid, imem_req_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int seen_inst;
    do_reset();
    inst_ready = 1'b1;
    rsp_lat    = 3;
    wait_req(ok);
    @(negedge clk);                     // now in WAIT, old response 2 cycles out
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    seen_inst = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inst_valid) seen_inst++;
      if (imem_req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || imem_req_addr !== 32'h8000_0100 || seen_inst != 0) begin
      n_fail++;
      $display("FAIL redir_wait_req: req=%b addr=%h inst_seen=%0d want 1 80000100 0",
               ok, imem_req_addr, seen_inst);
    end
    rsp_lat = 1;
    wait_inst(ok);
    n_checks++;
    if (!ok || inst_pc !== 32'h8000_0100 || inst !== 32'h7FFF_FEFF) begin
      n_fail++;
      $display("FAIL redir_wait_inst: ok=%b pc=%h inst=%h want 1 80000100 7ffffeff", ok, inst_pc, inst);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_hold();
    bit ok;
    do_reset();
    inst_ready = 1'b1;
    wait_inst(ok);
    redirect_valid = 1'b1;              // same cycle as the inst handshake
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (!ok || inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      n_fail++;
      $display("FAIL redir_hold: ok=%b iv=%b rv=%b addr=%h want 1 0 1 80000200",
               ok, inst_valid, imem_req_valid, imem_req_addr);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    bit ok;
    int reqs_before;
    int req_seen;
    do_reset();
    wait_inst(ok);
    reqs_before    = req_count;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    req_seen = (imem_req_valid === 1'b1) ? 1 : 0;
    wait_inst(ok);
    n_checks++;
    if (!ok || inst_fault !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h8000_0102) begin
      n_fail++;
      $display("FAIL misalign_inst: ok=%b fault=%b inst=%h pc=%h want 1 1 0 80000102",
               ok, inst_fault, inst, inst_pc);
    end
    n_checks++;
    if (req_seen != 0 || req_count != reqs_before) begin
      n_fail++;
      $display("FAIL misalign_noreq: req_valid_seen=%0d new_reqs=%0d want 0 0",
               req_seen, req_count - reqs_before);
    end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    wait_inst(ok);
    n_checks++;
    if (!ok || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0106 || req_count != reqs_before) begin
      n_fail++;
      $display("FAIL misalign_repeat: ok=%b fault=%b pc=%h new_reqs=%0d want 1 1 80000106 0",
               ok, inst_fault, inst_pc, req_count - reqs_before);
    end
  endtask

  task automatic test_bus_error();
    bit ok;
    do_reset();
    mem_err = 1'b1;
    wait_inst(ok);
    n_checks++;
    if (!ok || inst !== 32'h0 || inst_fault !== 1'b1 || inst_pc !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL buserr_inst: ok=%b inst=%h fault=%b pc=%h want 1 0 1 80000000",
               ok, inst, inst_fault, inst_pc);
    end
    mem_err    = 1'b0;
    inst_ready = 1'b1;
    wait_req(ok);
    n_checks++;
    if (!ok || imem_req_addr !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL buserr_next_req: ok=%b addr=%h want 1 80000004", ok, imem_req_addr);
    end
    wait_inst(ok);
    n_checks++;
    if (!ok || inst !== 32'h7FFF_FFFB || inst_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL buserr_recover: ok=%b inst=%h fault=%b want 1 7ffffffb 0", ok, inst, inst_fault);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit ok;
    int seen_inst;
    do_reset();
    rsp_lat = 3;
    wait_req(ok);
    @(negedge clk);                     // WAIT, response still pending
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_inst = 0;
    for (int i = 0; i < 4; i++) begin  // stale response pulses in here
      @(negedge clk);
      if (inst_valid) seen_inst++;
    end
    n_checks++;
    if (seen_inst != 0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL midrst_stale: inst_seen=%0d rv=%b addr=%h want 0 1 80000000",
               seen_inst, imem_req_valid, imem_req_addr);
    end
    rsp_lat        = 1;
    imem_req_ready = 1'b1;
    wait_inst(ok);
    n_checks++;
    if (!ok || inst_pc !== 32'h8000_0000 || inst !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL midrst_fetch: ok=%b pc=%h inst=%h want 1 80000000 7fffffff", ok, inst_pc, inst);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misaligned();
    test_bus_error();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
